// File: rtl/ntt_ctrl.sv
// Sequencer for a 256-point in-place NTT/INTT on the shared butterfly datapath.
// Walks every layer, issues read/twiddle addresses, and replays them as write-backs D cycles later.
module ntt_ctrl #(
  parameter int RD_LATENCY = 1,
  parameter int BF_LATENCY = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       sel_red_i,
  input  logic       sel_butterfly_i,
  output logic       rd_en_o,
  output logic [7:0] rd_addr_a_o,
  output logic [7:0] rd_addr_b_o,
  output logic [7:0] tw_addr_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_a_o,
  output logic [7:0] wr_addr_b_o,
  output logic       sel_red_o,
  output logic       sel_butterfly_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] state_o
);

  localparam int D   = RD_LATENCY + BF_LATENCY;
  localparam int DCW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [6:0]       cnt;
  logic [2:0]       shift;       // log2(len) of the current layer
  logic [DCW-1:0]   drain_cnt;
  logic [2:0]       start_shift;
  logic [2:0]       next_shift;
  logic             last_layer;

  logic             en_pipe [D];
  logic [7:0]       a_pipe  [D];
  logic [7:0]       b_pipe  [D];

  // Returns {a, b, tw} for butterfly c of the layer with len = 1 << s.
  function automatic logic [23:0] bf_addr(input logic [6:0] c, input logic [2:0] s,
                                          input logic inv);
    logic [7:0] mask, g, a, b, base, tw;
    mask = (8'd1 << s) - 8'd1;
    g    = {1'b0, c} >> s;
    a    = (g << ({1'b0, s} + 4'd1)) | ({1'b0, c} & mask);
    b    = a + (8'd1 << s);
    base = 8'd128 >> s;
    // Inverse index wraps mod 256 on the len=1 layer, giving 255 - g as required.
    tw   = inv ? ((base << 1) - 8'd1 - g) : (base + g);
    return {a, b, tw};
  endfunction

  assign start_shift = sel_butterfly_i ? {2'b00, sel_red_i} : 3'd7;
  assign next_shift  = sel_butterfly_o ? shift + 3'd1 : shift - 3'd1;
  assign last_layer  = sel_butterfly_o ? (shift == 3'd7) : (shift == {2'b00, sel_red_o});
  assign state_o     = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= 7'd0;
      shift           <= 3'd0;
      drain_cnt       <= '0;
      rd_en_o         <= 1'b0;
      rd_addr_a_o     <= 8'd0;
      rd_addr_b_o     <= 8'd0;
      tw_addr_o       <= 8'd0;
      sel_red_o       <= 1'b0;
      sel_butterfly_o <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            sel_red_o       <= sel_red_i;
            sel_butterfly_o <= sel_butterfly_i;
            shift           <= start_shift;
            cnt             <= 7'd0;
            state           <= ISSUE;
            busy_o          <= 1'b1;
            rd_en_o         <= 1'b1;
            {rd_addr_a_o, rd_addr_b_o, tw_addr_o} <=
              bf_addr(7'd0, start_shift, sel_butterfly_i);
          end
        end
        ISSUE: begin
          if (cnt == 7'd127) begin
            state       <= DRAIN;
            drain_cnt   <= '0;
            rd_en_o     <= 1'b0;
            rd_addr_a_o <= 8'd0;
            rd_addr_b_o <= 8'd0;
            tw_addr_o   <= 8'd0;
          end else begin
            cnt <= cnt + 7'd1;
            {rd_addr_a_o, rd_addr_b_o, tw_addr_o} <=
              bf_addr(cnt + 7'd1, shift, sel_butterfly_o);
          end
        end
        DRAIN: begin
          // Hold off the next layer until the last write-back has left the pipe.
          if (drain_cnt == DCW'(D - 1)) begin
            if (last_layer) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              shift   <= next_shift;
              cnt     <= 7'd0;
              state   <= ISSUE;
              rd_en_o <= 1'b1;
              {rd_addr_a_o, rd_addr_b_o, tw_addr_o} <=
                bf_addr(7'd0, next_shift, sel_butterfly_o);
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < D; i++) begin
        en_pipe[i] <= 1'b0;
        a_pipe[i]  <= 8'd0;
        b_pipe[i]  <= 8'd0;
      end
    end else begin
      en_pipe[0] <= rd_en_o;
      a_pipe[0]  <= rd_addr_a_o;
      b_pipe[0]  <= rd_addr_b_o;
      for (int i = 1; i < D; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        a_pipe[i]  <= a_pipe[i-1];
        b_pipe[i]  <= b_pipe[i-1];
      end
    end
  end

  assign wr_en_o     = en_pipe[D-1];
  assign wr_addr_a_o = a_pipe[D-1];
  assign wr_addr_b_o = b_pipe[D-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: a D=1 and a D=3 instance checked cycle by cycle against an
// arithmetic model of the NTT address schedule.
module tb_ntt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2, sel_red, sel_bf;

  logic       rd_en1, wr_en1, sr1, sb1, busy1, done1;
  logic [7:0] ra1, rb1, tw1, wa1, wb1;
  logic [1:0] st1;
  logic       rd_en2, wr_en2, sr2, sb2, busy2, done2;
  logic [7:0] ra2, rb2, tw2, wa2, wb2;
  logic [1:0] st2;

  ntt_ctrl #(.RD_LATENCY(1), .BF_LATENCY(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sel_red_i(sel_red),
    .sel_butterfly_i(sel_bf), .rd_en_o(rd_en1), .rd_addr_a_o(ra1), .rd_addr_b_o(rb1),
    .tw_addr_o(tw1), .wr_en_o(wr_en1), .wr_addr_a_o(wa1), .wr_addr_b_o(wb1),
    .sel_red_o(sr1), .sel_butterfly_o(sb1), .busy_o(busy1), .done_o(done1), .state_o(st1));

  ntt_ctrl #(.RD_LATENCY(2), .BF_LATENCY(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .sel_red_i(sel_red),
    .sel_butterfly_i(sel_bf), .rd_en_o(rd_en2), .rd_addr_a_o(ra2), .rd_addr_b_o(rb2),
    .tw_addr_o(tw2), .wr_en_o(wr_en2), .wr_addr_a_o(wa2), .wr_addr_b_o(wb2),
    .sel_red_o(sr2), .sel_butterfly_o(sb2), .busy_o(busy2), .done_o(done2), .state_o(st2));

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  logic       s_re, s_we, s_bz, s_dn, s_sr, s_sb;
  logic [7:0] s_ra, s_rb, s_tw, s_wa, s_wb;

  logic [7:0] obs_a  [0:1100];
  logic [7:0] obs_b  [0:1100];
  logic [7:0] obs_tw [0:1100];
  logic       obs_wr [0:1100];
  logic       obs_dn [0:1100];

  task automatic sample(input bit d3);
    if (d3) begin
      s_re = rd_en2; s_we = wr_en2; s_bz = busy2; s_dn = done2; s_sr = sr2; s_sb = sb2;
      s_ra = ra2; s_rb = rb2; s_tw = tw2; s_wa = wa2; s_wb = wb2;
    end else begin
      s_re = rd_en1; s_we = wr_en1; s_bz = busy1; s_dn = done1; s_sr = sr1; s_sb = sb1;
      s_ra = ra1; s_rb = rb1; s_tw = tw1; s_wa = wa1; s_wb = wb1;
    end
  endtask

  // Expected behaviour in cycle k after the start edge, straight from len/g/o arithmetic.
  function automatic void model(input bit red, input bit inv, input int d, input int k,
                                output bit en, output bit busy, output bit done,
                                output int a, output int b, output int tw);
    int per, total, l, pos, len, g, o;
    en = 0; busy = 0; done = 0; a = 0; b = 0; tw = 0;
    per   = 128 + d;
    total = (red ? 7 : 8) * per;
    if (k >= 1 && k <= total) begin
      busy = 1;
      l    = (k - 1) / per;
      pos  = (k - 1) % per;
      len  = inv ? ((red ? 2 : 1) * (2 ** l)) : (128 / (2 ** l));
      if (pos < 128) begin
        en = 1;
        g  = pos / len;
        o  = pos % len;
        a  = 2 * len * g + o;
        b  = a + len;
        tw = inv ? (2 * (128 / len) - 1 - g) : (128 / len + g);
      end
    end else if (k == total + 1) begin
      done = 1;
    end
  endfunction

  task automatic run_case(input string name, input bit red, input bit inv, input bit d3,
                          input int glitch_at, input int rst_at);
    int d, total, wr_cnt, done_cnt;
    bit e_en, e_bz, e_dn, w_en, w_bz, w_dn;
    int ea, eb, etw, wa, wb, wtw;
    logic [15:0] exp_w;
    d = d3 ? 3 : 1;
    total = (red ? 7 : 8) * (128 + d);
    wr_cnt = 0;
    done_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    sel_red = red;
    sel_bf  = inv;
    if (d3) start2 = 1'b1; else start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= total + 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      start2 = 1'b0;
      sel_red = 1'($urandom_range(0, 1));
      sel_bf  = 1'($urandom_range(0, 1));
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        sample(d3);
        checks++;
        if ({s_re, s_we, s_bz, s_dn, s_sr, s_sb, s_ra, s_rb, s_tw, s_wa, s_wb} !== '0) begin
          failures++;
          $display("FAIL %s async_reset cyc=%0d got=%b/%b/%b/%b/%b/%b %h %h %h %h %h exp=all zero",
                   name, k, s_re, s_we, s_bz, s_dn, s_sr, s_sb, s_ra, s_rb, s_tw, s_wa, s_wb);
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      sample(d3);
      model(red, inv, d, k, e_en, e_bz, e_dn, ea, eb, etw);
      model(red, inv, d, k - d, w_en, w_bz, w_dn, wa, wb, wtw);
      checks++;
      if ({s_re, s_we, s_bz, s_dn, s_sr, s_sb} !== {e_en, w_en, e_bz, e_dn, red, inv}) begin
        failures++;
        $display("FAIL %s ctrl cyc=%0d got rd/wr/busy/done/red/bf=%b exp=%b", name, k,
                 {s_re, s_we, s_bz, s_dn, s_sr, s_sb}, {e_en, w_en, e_bz, e_dn, red, inv});
      end
      if (e_en) begin
        exp_q.push_back({8'(ea), 8'(eb)});
        checks++;
        if ({s_ra, s_rb, s_tw} !== {8'(ea), 8'(eb), 8'(etw)}) begin
          failures++;
          $display("FAIL %s rd_addr cyc=%0d got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d",
                   name, k, s_ra, s_rb, s_tw, ea, eb, etw);
        end
      end
      if (s_we === 1'b1) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s wr_unexpected cyc=%0d got wa=%0d wb=%0d exp no write",
                   name, k, s_wa, s_wb);
        end else begin
          exp_w = exp_q.pop_front();
          if ({s_wa, s_wb} !== exp_w) begin
            failures++;
            $display("FAIL %s wr_addr cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d",
                     name, k, s_wa, s_wb, exp_w[15:8], exp_w[7:0]);
          end
        end
      end
      if (s_dn === 1'b1) done_cnt++;
      obs_a[k] = s_ra; obs_b[k] = s_rb; obs_tw[k] = s_tw;
      obs_wr[k] = s_we; obs_dn[k] = s_dn;
      // Start requests during a run and in the DONE cycle must have no effect.
      if (glitch_at != 0 && (k == glitch_at || k == total + 1)) begin
        if (d3) start2 = 1'b1; else start = 1'b1;
      end
    end
    checks++;
    if (wr_cnt != (red ? 7 : 8) * 128 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s wr_count got=%0d left=%0d exp=%0d left=0", name, wr_cnt,
               exp_q.size(), (red ? 7 : 8) * 128);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt);
    end
  endtask

  task automatic spot(input string name, input int k, input int a, input int b, input int tw);
    checks++;
    if ({obs_a[k], obs_b[k], obs_tw[k]} !== {8'(a), 8'(b), 8'(tw)}) begin
      failures++;
      $display("FAIL %s cyc=%0d got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d",
               name, k, obs_a[k], obs_b[k], obs_tw[k], a, b, tw);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; sel_red = 1'b1; sel_bf = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en1, wr_en1, busy1, done1, sr1, sb1, ra1, rb1, tw1, wa1, wb1,
         rd_en2, wr_en2, busy2, done2, sr2, sb2, ra2, rb2, tw2, wa2, wb2} !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%b/%b rd=%b/%b exp=all zero", busy1, busy2,
               rd_en1, rd_en2);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_kyber_fwd();
    run_case("kyber_fwd", 1'b1, 1'b0, 1'b0, 0, 0);
    spot("kyf_c0", 1, 0, 128, 1);
    spot("kyf_c127", 128, 127, 255, 1);
    spot("kyf_l1_c64", 194, 128, 192, 3);
    spot("kyf_last_c0", 775, 0, 2, 64);
    spot("kyf_last_c127", 902, 253, 255, 127);
    checks++;
    if ({obs_dn[903], obs_dn[904], obs_dn[905]} !== 3'b010) begin
      failures++;
      $display("FAIL kyf_done_cycle got=%b exp=010", {obs_dn[903], obs_dn[904], obs_dn[905]});
    end
  endtask

  task automatic test_dil_fwd();
    run_case("dil_fwd", 1'b0, 1'b0, 1'b0, 0, 0);
    spot("dlf_last_c127", 1031, 254, 255, 255);
    checks++;
    if ({obs_dn[1032], obs_dn[1033]} !== 2'b01) begin
      failures++;
      $display("FAIL dlf_done_cycle got=%b exp=01", {obs_dn[1032], obs_dn[1033]});
    end
  endtask

  task automatic test_kyber_inv();
    run_case("kyber_inv", 1'b1, 1'b1, 1'b0, 0, 0);
    spot("kyi_first_c0", 1, 0, 2, 127);
    spot("kyi_last_c0", 775, 0, 128, 1);
  endtask

  task automatic test_dil_inv();
    run_case("dil_inv", 1'b0, 1'b1, 1'b0, 0, 0);
    spot("dli_first_c0", 1, 0, 1, 255);
  endtask

  task automatic test_start_ignored();
    run_case("start_glitch", 1'b1, 1'b0, 1'b0, $urandom_range(200, 800), 0);
  endtask

  task automatic test_reset_midrun();
    run_case("rst_midrun", 1'b0, 1'b0, 1'b0, 0, 500);
    run_case("after_rst", 1'b1, 1'b1, 1'b0, 0, 0);
    spot("after_rst_c0", 1, 0, 2, 127);
  endtask

  task automatic test_latency3();
    run_case("d3_kyber_fwd", 1'b1, 1'b0, 1'b1, 0, 0);
    spot("d3_l1_c0", 132, 0, 64, 2);
    checks++;
    if ({obs_wr[3], obs_wr[4], obs_dn[917], obs_dn[918]} !== 4'b0101) begin
      failures++;
      $display("FAIL d3_timing got wr3/wr4/dn917/dn918=%b exp=0101",
               {obs_wr[3], obs_wr[4], obs_dn[917], obs_dn[918]});
    end
  endtask

  initial begin
    test_reset();
    test_kyber_fwd();
    test_dil_fwd();
    test_kyber_inv();
    test_dil_inv();
    test_start_ignored();
    test_reset_midrun();
    test_latency3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
